// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin arbiter for 8 requesters with a hold limit.
// Grant, index, valid and timeout are all registered outputs.
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       rel,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam int CW = $clog2(MAX_HOLD);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_HOLD - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_d;
    logic [2:0]    ptr, ptr_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [7:0]    gnt_d;
    logic [2:0]    idx_d;
    logic          vld_d, to_d;
    logic          found;
    logic [2:0]    win;
    logic          drop, at_limit;

    // Rotating search starting at ptr; wraps past 7 naturally in 3 bits.
    always_comb begin
        found = 1'b0;
        win   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!found && req[ptr + 3'(i)]) begin
                found = 1'b1;
                win   = ptr + 3'(i);
            end
        end
    end

    assign drop     = rel || !req[gnt_idx];
    assign at_limit = (cnt == LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            cnt       <= '0;
            gnt       <= 8'd0;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            cnt       <= cnt_d;
            gnt       <= gnt_d;
            gnt_idx   <= idx_d;
            gnt_valid <= vld_d;
            timeout   <= to_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: if (found) state_d = BUSY;
            BUSY: if (drop || at_limit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d = gnt;
        idx_d = gnt_idx;
        vld_d = gnt_valid;
        ptr_d = ptr;
        cnt_d = cnt;
        to_d  = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    gnt_d = 8'd1 << win;
                    idx_d = win;
                    vld_d = 1'b1;
                    ptr_d = win + 3'd1;
                    cnt_d = '0;
                end
            end
            BUSY: begin
                // Release/drop outranks the limit, so a tie never times out.
                if (drop || at_limit) begin
                    gnt_d = 8'd0;
                    idx_d = 3'd0;
                    vld_d = 1'b0;
                    to_d  = !drop;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: begin
                gnt_d = 8'd0;
                idx_d = 3'd0;
                vld_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed stimulus for rr_arbiter8 (MAX_HOLD=4) with
// a per-cycle behavioural model and hand-computed literal expectations.
module tb_rr_arbiter8;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'd0;
    logic       rel = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_to    = 1'b0;

    rr_arbiter8 #(.MAX_HOLD(MH)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .rel(rel),
        .gnt(gnt),
        .gnt_idx(gnt_idx),
        .gnt_valid(gnt_valid),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic int pick(logic [7:0] r, int p);
        for (int k = 0; k < 8; k++)
            if (r[(p + k) % 8]) return (p + k) % 8;
        return -1;
    endfunction

    function automatic logic [7:0] onehot(int o);
        return (o < 0) ? 8'd0 : 8'(1 << o);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: owner index, grant age in cycles, next-priority pointer.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner <= -1;
            m_ptr   <= 0;
            m_held  <= 0;
            m_to    <= 1'b0;
        end else begin
            m_to <= 1'b0;
            if (m_owner < 0) begin
                if (req != 8'd0) begin
                    m_owner <= pick(req, m_ptr);
                    m_ptr   <= (pick(req, m_ptr) + 1) % 8;
                    m_held  <= 1;
                end
            end else if (rel || !req[m_owner[2:0]]) begin
                m_owner <= -1;
            end else if (m_held == MH) begin
                m_owner <= -1;
                m_to    <= 1'b1;
            end else begin
                m_held <= m_held + 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("gnt", gnt, onehot(m_owner));
        chk("gnt_idx", gnt_idx, (m_owner < 0) ? 0 : m_owner);
        chk("gnt_valid", gnt_valid, m_owner >= 0);
        chk("timeout", timeout, m_to);
        chk("onehot", $countones(gnt) <= 1, 1);
        chk("to_vs_valid", timeout && gnt_valid, 0);
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        #2 rst = 1'b0;
    endtask

    initial begin
        repeat (2) cyc();
        chk("rst_gnt", gnt, 8'h00);
        chk("rst_valid", gnt_valid, 0);
        rst = 1'b0;

        // basic grant and release
        req = 8'h01;
        cyc();
        chk("basic_gnt", gnt, 8'h01);
        chk("basic_idx", gnt_idx, 0);
        chk("basic_valid", gnt_valid, 1);
        rel = 1'b1;
        cyc();
        chk("basic_rel", gnt, 8'h00);
        rel = 1'b0;
        req = 8'h00;
        cyc();

        // full rotation from a fresh pointer, last grant checks wrap 7->0
        do_reset();
        for (int k = 0; k < 9; k++) begin
            req = (k == 8) ? 8'h81 : 8'hFF;
            cyc();
            chk("rot_idx", gnt_idx, k % 8);
            rel = 1'b1;
            cyc();
            chk("rot_dead", gnt_valid, 0);
            rel = 1'b0;
        end

        // ptr is 1: grant 2 to move it to 3, then 06 must wrap to 1
        req = 8'h04;
        cyc();
        chk("pre_wrap", gnt_idx, 2);
        rel = 1'b1;
        cyc();
        rel = 1'b0;
        req = 8'h06;
        cyc();
        chk("wrap_pick", gnt_idx, 1);
        rel = 1'b1;
        cyc();
        rel = 1'b0;

        // hold limit: 4 cycles of grant, then one timeout cycle
        req = 8'h04;
        for (int k = 0; k < MH; k++) begin
            cyc();
            chk("hold_gnt", gnt, 8'h04);
        end
        cyc();
        chk("limit_gnt", gnt, 8'h00);
        chk("limit_to", timeout, 1);
        cyc();
        chk("regrant", gnt, 8'h04);
        chk("regrant_to", timeout, 0);

        // owner drops its request mid-grant
        cyc();
        req = 8'h00;
        cyc();
        chk("drop_gnt", gnt, 8'h00);
        chk("drop_to", timeout, 0);

        // release in the last allowed cycle beats the limit
        req = 8'h08;
        for (int k = 0; k < MH; k++) begin
            cyc();
            chk("tie_hold", gnt, 8'h08);
        end
        rel = 1'b1;
        cyc();
        chk("tie_gnt", gnt, 8'h00);
        chk("tie_to", timeout, 0);
        rel = 1'b0;
        req = 8'h00;
        cyc();

        // asynchronous reset between edges while requester 5 owns
        req = 8'h20;
        cyc();
        chk("pre_rst", gnt, 8'h20);
        #1 rst = 1'b1;
        #1;
        chk("arst_gnt", gnt, 8'h00);
        chk("arst_idx", gnt_idx, 0);
        chk("arst_valid", gnt_valid, 0);
        chk("arst_to", timeout, 0);
        req = 8'hFF;
        rst = 1'b0;
        cyc();
        chk("post_rst", gnt, 8'h01);
        rel = 1'b1;
        cyc();
        rel = 1'b0;
        cyc();
        chk("post_rst2", gnt_idx, 1);
        repeat (3) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter that shares one downstream resource between 8 requesters. It rotates priority through an internal pointer, grants exactly one requester at a time, and holds that grant until the owner releases it or a hold limit expires. Its one-hot grant vector sits directly in front of the 8x3 encoder: the encoder turns the one-hot grant into the binary owner index for the shared datapath mux.

## Interface

Parameters:
- MAX_HOLD, 16: maximum number of consecutive cycles a grant may be held; legal range 2..256.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request vector; bit i is requester i, level-sensitive.
- release  input  1  the current owner is finished; sampled only in BUSY.
- gnt  output  8  one-hot grant; all zero when idle.
- gnt_idx  output  3  binary index of the owner; 0 when idle.
- gnt_valid  output  1  high while any grant is active (equals |gnt).
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

## Operation

- Two states: IDLE and BUSY. All state is registered, and all outputs are registered.
- Internal registers:
  - ptr[2:0] holds the highest-priority index.
  - cnt holds the hold count and is wide enough to represent MAX_HOLD-1.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise the winner is the first set bit of req, searching ptr, ptr+1, … 7, 0, … ptr-1.
  - At the edge: gnt <= onehot(winner), gnt_idx <= winner, gnt_valid <= 1, ptr <= (winner+1) mod 8, cnt <= 0, state -> BUSY.
- BUSY, evaluated at each edge in priority order:
  1. release == 1, or req[gnt_idx] == 0 (the owner dropped its request): clear the grant, state -> IDLE, no timeout.
  2. cnt == MAX_HOLD-1: clear the grant, pulse timeout for one cycle, state -> IDLE.
  3. Otherwise: cnt <= cnt+1 and hold the grant unchanged.
- Changes to other requesters' req bits have no effect during BUSY. There is no preemption.
- release is ignored in IDLE.
- At most one bit of gnt is ever set. gnt_idx always equals the encoded value of gnt.
- Reset (asynchronous, active-high): gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, ptr=0, cnt=0, state=IDLE. This takes effect immediately, including mid-grant. The first arbitration after reset favours requester 0.

## Timing

- Grant latency: req is sampled at edge N, and gnt is valid after edge N (visible in cycle N+1).
- Grant duration: a grant lasts at least 1 cycle and at most MAX_HOLD cycles.
- Release: when release is sampled high at edge M, gnt clears after edge M.
- Dead cycle: there is always at least one IDLE cycle between consecutive grants, so back-to-back owners are separated by exactly 1 cycle when requests are pending.
- timeout is high in the same cycle that gnt first reads zero after a forced revoke. It is never high together with gnt_valid.
- release and the limit in the same cycle: release wins and timeout stays 0.
- Pointer wrap: when the winner is 7, ptr becomes 0.
- Fairness: under continuous requests, every requester is granted within 8 grants.

## Test plan

- Basic grant: reset, then req=8'b0000_0001 → one edge later gnt=8'b0000_0001, gnt_idx=3'b000, gnt_valid=1. Pulse release → gnt=0 next cycle.
- Full rotation: req=8'hFF held, release pulsed in each grant cycle → gnt_idx sequence 0,1,2,…,7,0, with exactly one idle cycle between grants.
- Wrap and priority: after requester 7 is granted and released, req=8'b1000_0001 → requester 0 is granted. With ptr=3 and req=8'b0000_0110 → requester 1 is granted (search wraps past 7).
- Hold limit (MAX_HOLD=4): req=8'b0000_0100 held, release=0 → gnt=8'b0000_0100 for exactly 4 cycles, then gnt=0 with timeout=1 for 1 cycle, then requester 2 is re-granted in the following cycle.
- Owner drop and tie: the owner deasserts its req mid-grant → gnt clears next edge with timeout=0. Separately, assert release in the final allowed hold cycle → no timeout pulse.
- Asynchronous reset mid-grant: assert rst between clock edges while gnt=8'b0010_0000 → all outputs read 0 before the next edge. After deassertion with req=8'hFF → requester 0 is granted first.
